// File: rtl/led_frame_arbiter.sv
// ---------------------------------------------------------------------------
// led_frame_arbiter
//
// Owns the 4x8 LED frame presented to the matrix scan driver. Two requesters
// write one row byte per req/ack handshake under round-robin arbitration.
//
// Build option:
//   LED_FRAME_DOUBLE_BUFFER_EN defined   - writes land in a back buffer; a
//       commit copies back -> front only at a frame boundary so the scan
//       never shows a half-updated frame.
//   LED_FRAME_DOUBLE_BUFFER_EN undefined - single buffer; grants write the
//       displayed rows directly, commit is acknowledged on the next cycle.
//
// Parameters:
//   FRAME_CYCLES  clocks per display frame (>= 2), matches the scan driver
//
// Ports:
//   clk12MHz, resetn        clock, async active-low reset
//   req_x/row_x/data_x      requester x write request, target row, row byte
//   ack_x                   one-cycle write acknowledge (x = a, b)
//   commit                  single-cycle back -> front swap request
//   swap_pending            a commit is waiting for the frame boundary
//   swap_done               one-cycle pulse, front rows just updated
//   leds1..leds4            displayed rows 0..3, to the scan driver
// ---------------------------------------------------------------------------
module led_frame_arbiter #(
    parameter int unsigned FRAME_CYCLES = 4096
) (
    input  logic       clk12MHz,
    input  logic       resetn,
    input  logic       req_a,
    input  logic [1:0] row_a,
    input  logic [7:0] data_a,
    output logic       ack_a,
    input  logic       req_b,
    input  logic [1:0] row_b,
    input  logic [7:0] data_b,
    output logic       ack_b,
    input  logic       commit,
    output logic       swap_pending,
    output logic       swap_done,
    output logic [7:0] leds1,
    output logic [7:0] leds2,
    output logic [7:0] leds3,
    output logic [7:0] leds4
);

    localparam int unsigned ROWS  = 4;
    localparam int unsigned ROW_W = 8;

    // Round-robin pointer encoding: which requester was granted last
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Elaboration-time guard on the frame length
    if (FRAME_CYCLES < 2) begin : g_frame_cycles_check
        $error("led_frame_arbiter: FRAME_CYCLES must be >= 2");
    end

    logic                       ack_a_q, ack_a_d;
    logic                       ack_b_q, ack_b_d;
    logic                       last_q, last_d;
    logic                       swap_done_q, swap_done_d;
    logic [ROWS-1:0][ROW_W-1:0] front_q, front_d;

    logic elig_a, elig_b;
    logic grant_a, grant_b;

    // Arbitration: a requester in its ack cycle is not eligible, so a request
    // still held during the ack is never written twice.
    always_comb begin
        elig_a  = req_a & ~ack_a_q;
        elig_b  = req_b & ~ack_b_q;
        grant_a = elig_a & (~elig_b | (last_q == SEL_B));
        grant_b = elig_b & (~elig_a | (last_q == SEL_A));

        ack_a_d = grant_a;
        ack_b_d = grant_b;

        last_d = last_q;
        if (grant_a) begin
            last_d = SEL_A;
        end else if (grant_b) begin
            last_d = SEL_B;
        end
    end

    // Handshake, pointer and displayed-row registers
    always_ff @(posedge clk12MHz or negedge resetn) begin
        if (!resetn) begin
            ack_a_q     <= 1'b0;
            ack_b_q     <= 1'b0;
            last_q      <= SEL_B;
            swap_done_q <= 1'b0;
            front_q     <= '0;
        end else begin
            ack_a_q     <= ack_a_d;
            ack_b_q     <= ack_b_d;
            last_q      <= last_d;
            swap_done_q <= swap_done_d;
            front_q     <= front_d;
        end
    end

`ifdef LED_FRAME_DOUBLE_BUFFER_EN

    localparam int unsigned CNT_W = $clog2(FRAME_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [ROWS-1:0][ROW_W-1:0] back_q, back_d;
    logic                       pending_q, pending_d;
    logic                       wrap;
    logic                       swap;

    // Frame counter, back-buffer writes and boundary-aligned swap.
    // The swap copies back_q, i.e. the pre-edge contents, so a write granted
    // at the swap edge lands in back only and waits for the next commit.
    always_comb begin
        cnt_d       = cnt_q + CNT_W'(1);
        back_d      = back_q;
        front_d     = front_q;
        pending_d   = pending_q | commit;
        swap_done_d = 1'b0;

        wrap = (cnt_q == CNT_LAST);
        swap = wrap & (pending_q | commit);

        if (wrap) begin
            cnt_d = '0;
        end

        if (grant_a) begin
            back_d[row_a] = data_a;
        end else if (grant_b) begin
            back_d[row_b] = data_b;
        end

        if (swap) begin
            front_d     = back_q;
            pending_d   = 1'b0;
            swap_done_d = 1'b1;
        end
    end

    // Back buffer, frame counter and pending-swap registers
    always_ff @(posedge clk12MHz or negedge resetn) begin
        if (!resetn) begin
            cnt_q     <= '0;
            back_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            back_q    <= back_d;
            pending_q <= pending_d;
        end
    end

    assign swap_pending = pending_q;

`else

    // Single buffer: grants update the displayed rows directly
    always_comb begin
        front_d = front_q;
        if (grant_a) begin
            front_d[row_a] = data_a;
        end else if (grant_b) begin
            front_d[row_b] = data_b;
        end
        swap_done_d = commit;
    end

    assign swap_pending = 1'b0;

`endif

    assign ack_a     = ack_a_q;
    assign ack_b     = ack_b_q;
    assign swap_done = swap_done_q;
    assign leds1     = front_q[0];
    assign leds2     = front_q[1];
    assign leds3     = front_q[2];
    assign leds4     = front_q[3];

endmodule

// File: tb/tb_led_frame_arbiter.sv
// Bench for led_frame_arbiter: directed scenarios plus a randomized phase,
// all checked against a transaction-level model of the frame buffers.
module tb_led_frame_arbiter;

    localparam int unsigned FC = 8;

    logic       clk12MHz = 1'b0;
    logic       resetn   = 1'b0;
    logic       req_a    = 1'b0;
    logic [1:0] row_a    = '0;
    logic [7:0] data_a   = '0;
    logic       ack_a;
    logic       req_b    = 1'b0;
    logic [1:0] row_b    = '0;
    logic [7:0] data_b   = '0;
    logic       ack_b;
    logic       commit   = 1'b0;
    logic       swap_pending;
    logic       swap_done;
    logic [7:0] leds1, leds2, leds3, leds4;

    led_frame_arbiter #(.FRAME_CYCLES(FC)) dut (
        .clk12MHz    (clk12MHz),
        .resetn      (resetn),
        .req_a       (req_a),
        .row_a       (row_a),
        .data_a      (data_a),
        .ack_a       (ack_a),
        .req_b       (req_b),
        .row_b       (row_b),
        .data_b      (data_b),
        .ack_b       (ack_b),
        .commit      (commit),
        .swap_pending(swap_pending),
        .swap_done   (swap_done),
        .leds1       (leds1),
        .leds2       (leds2),
        .leds3       (leds3),
        .leds4       (leds4)
    );

    initial forever #5 clk12MHz = ~clk12MHz;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit          m_ack_a, m_ack_b, m_last_b, m_pend, m_done;
    logic [7:0]  m_front [4];
`ifdef LED_FRAME_DOUBLE_BUFFER_EN
    logic [7:0]  m_back  [4];
    int unsigned m_cyc;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ack_a  = 1'b0;
        m_ack_b  = 1'b0;
        m_last_b = 1'b1;
        m_pend   = 1'b0;
        m_done   = 1'b0;
        for (int i = 0; i < 4; i++) m_front[i] = 8'h00;
`ifdef LED_FRAME_DOUBLE_BUFFER_EN
        for (int i = 0; i < 4; i++) m_back[i] = 8'h00;
        m_cyc = 0;
`endif
    endtask

    task automatic check_all();
        chk("ack_a",        32'(ack_a),        32'(m_ack_a));
        chk("ack_b",        32'(ack_b),        32'(m_ack_b));
        chk("swap_pending", 32'(swap_pending), 32'(m_pend));
        chk("swap_done",    32'(swap_done),    32'(m_done));
        chk("leds1",        32'(leds1),        32'(m_front[0]));
        chk("leds2",        32'(leds2),        32'(m_front[1]));
        chk("leds3",        32'(leds3),        32'(m_front[2]));
        chk("leds4",        32'(leds4),        32'(m_front[3]));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ack_a"}, 32'(ack_a), 32'd0);
        chk({tag, "_ack_b"}, 32'(ack_b), 32'd0);
        chk({tag, "_pend"},  32'(swap_pending), 32'd0);
        chk({tag, "_done"},  32'(swap_done), 32'd0);
        chk({tag, "_leds"},  32'({leds1, leds2, leds3, leds4}), 32'd0);
    endtask

    // Advance one clock: predict the edge from the current inputs, then check
    task automatic tick();
        bit ea, eb, ga, gb;
`ifdef LED_FRAME_DOUBLE_BUFFER_EN
        bit         swap;
        logic [7:0] snap [4];
`endif
        ea = req_a && !m_ack_a;
        eb = req_b && !m_ack_b;
        ga = ea && (!eb || m_last_b);
        gb = eb && !ga;
`ifdef LED_FRAME_DOUBLE_BUFFER_EN
        swap = ((m_cyc % FC) == FC - 1) && (m_pend || commit);
        snap = m_back;
        if (ga) m_back[row_a] = data_a;
        if (gb) m_back[row_b] = data_b;
        if (swap) m_front = snap;
        m_pend = !swap && (m_pend || commit);
        m_done = swap;
        m_cyc++;
`else
        if (ga) m_front[row_a] = data_a;
        if (gb) m_front[row_b] = data_b;
        m_done = commit;
`endif
        m_ack_a = ga;
        m_ack_b = gb;
        if (ga) m_last_b = 1'b0;
        if (gb) m_last_b = 1'b1;
        @(posedge clk12MHz);
        #1;
        check_all();
    endtask

    // Assert reset between edges, check async clear, release after two edges
    task automatic do_reset(input string tag);
        req_a  = 1'b0;
        req_b  = 1'b0;
        commit = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        check_zero(tag);
        model_reset();
        @(posedge clk12MHz);
        @(posedge clk12MHz);
        #1;
        resetn = 1'b1;
    endtask

    // Idle until the next edge is at the given frame phase (double buffer only)
    task automatic align_phase(input int unsigned ph);
`ifdef LED_FRAME_DOUBLE_BUFFER_EN
        for (int k = 0; k < 2 * FC && (m_cyc % FC) != ph; k++) tick();
`else
        if (ph > FC) tick();
`endif
    endtask

    int n_a, n_b, n_done;

    initial begin
        model_reset();
        @(posedge clk12MHz);
        #1;
        do_reset("rst0");
        tick();

        // A writes row 2 = 0xA5, then commit
        do_reset("rst1");
        req_a = 1'b1; row_a = 2'd2; data_a = 8'hA5;
        tick();
        chk("t1_ack", 32'(ack_a), 32'd1);
        req_a = 1'b0;
        tick();
`ifdef LED_FRAME_DOUBLE_BUFFER_EN
        chk("t1_leds3_before", 32'(leds3), 32'h00);
`else
        chk("t1_leds3_before", 32'(leds3), 32'hA5);
`endif
        commit = 1'b1;
        tick();
        commit = 1'b0;
        for (int k = 0; k < FC + 2 && !m_done; k++) tick();
        chk("t1_leds3_after", 32'(leds3), 32'hA5);
        chk("t1_done", 32'(swap_done), 32'd1);

        // Both requesters contend for 4 writes each
        do_reset("rst2");
        n_a = 0; n_b = 0;
        req_a = 1'b1; row_a = 2'd0; data_a = 8'h10;
        req_b = 1'b1; row_b = 2'd1; data_b = 8'h20;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t2_ack_a", 32'(ack_a), 32'((k % 2) == 0));
            chk("t2_ack_b", 32'(ack_b), 32'((k % 2) == 1));
            if (m_ack_a) begin
                n_a++; data_a = 8'(8'h10 + n_a);
                if (n_a == 4) req_a = 1'b0;
            end
            if (m_ack_b) begin
                n_b++; data_b = 8'(8'h20 + n_b);
                if (n_b == 4) req_b = 1'b0;
            end
        end
        tick();

        // Single requester held continuously
        req_a = 1'b1; row_a = 2'd3; data_a = 8'h11;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("t3_ack_a", 32'(ack_a), 32'((k % 2) == 0));
        end
        req_a = 1'b0;
        tick();

        // Write at the same edge as a swap
        do_reset("rst3");
        req_a = 1'b1; row_a = 2'd0; data_a = 8'h0F;
        tick();
        req_a = 1'b0;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        align_phase(FC - 1);
        req_a = 1'b1; data_a = 8'hFF;
        tick();
        req_a = 1'b0;
`ifdef LED_FRAME_DOUBLE_BUFFER_EN
        chk("t4_leds1_swap", 32'(leds1), 32'h0F);
        chk("t4_done", 32'(swap_done), 32'd1);
`else
        chk("t4_leds1_swap", 32'(leds1), 32'hFF);
`endif
        commit = 1'b1;
        tick();
        commit = 1'b0;
        for (int k = 0; k < FC + 2 && !m_done; k++) tick();
        chk("t4_leds1_next", 32'(leds1), 32'hFF);

        // Two commits within one frame
        do_reset("rst4");
        align_phase(1);
        n_done = 0;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        n_done += int'(swap_done);
`ifdef LED_FRAME_DOUBLE_BUFFER_EN
        chk("t5_pend", 32'(swap_pending), 32'd1);
`endif
        tick();
        n_done += int'(swap_done);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        n_done += int'(swap_done);
        for (int k = 0; k < 2 * FC; k++) begin
            tick();
            n_done += int'(swap_done);
        end
`ifdef LED_FRAME_DOUBLE_BUFFER_EN
        chk("t5_done_count", 32'(n_done), 32'd1);
`else
        chk("t5_done_count", 32'(n_done), 32'd2);
`endif

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            req_a  = ($urandom_range(0, 3) != 0);
            row_a  = 2'($urandom_range(0, 3));
            data_a = 8'($urandom);
            req_b  = ($urandom_range(0, 3) != 0);
            row_b  = 2'($urandom_range(0, 3));
            data_b = 8'($urandom);
            commit = ($urandom_range(0, 15) == 0);
            tick();
        end
        req_a = 1'b0; req_b = 1'b0; commit = 1'b0;
        tick();

        // Reset with a swap pending and A in its ack cycle
        do_reset("rst5");
        align_phase(1);
        req_a = 1'b1; row_a = 2'd1; data_a = 8'h3C;
        commit = 1'b1;
        tick();
        req_a = 1'b0; commit = 1'b0;
        chk("t6_ack_before", 32'(ack_a), 32'd1);
        do_reset("t6_async");
        n_done = 0;
        for (int k = 0; k < FC + 3; k++) begin
            tick();
            n_done += int'(swap_done);
        end
        chk("t6_no_swap", 32'(n_done), 32'd0);
        chk("t6_leds2", 32'(leds2), 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_frame_arbiter.md
# led_frame_arbiter

Owns the 4×8 LED frame shown by the matrix scan driver and shares write access to it between two requesters. Each requester writes one row byte per req/ack handshake, with round-robin arbitration. Writes land in a back buffer. A commit request copies the back buffer to the displayed front buffer only at a frame boundary, so the scan never shows a half-updated frame. Sits between application logic (two sources) and the scan driver's `leds1..leds4` inputs.

## Interface
Parameters:
- `FRAME_CYCLES`, default 4096: length of one display frame in clocks; must match the scan driver's full row cycle. Legal range ≥ 2.

Ports:
- `clk12MHz` in 1: system clock, 12 MHz.
- `resetn` in 1: reset, asynchronous, active-low.
- `req_a` in 1: requester A write request; held until `ack_a`.
- `row_a` in 2: target row, 0..3 → `leds1..leds4`.
- `data_a` in 8: row byte; bit n = LED n+1, 1 = lit.
- `ack_a` out 1: one-cycle write acknowledge to A.
- `req_b`, `row_b`, `data_b`, `ack_b`: same as A, for requester B.
- `commit` in 1: single-cycle pulse requesting a back→front swap.
- `swap_pending` out 1: a commit is waiting for the frame boundary.
- `swap_done` out 1: one-cycle pulse, front buffer updated.
- `leds1`, `leds2`, `leds3`, `leds4` out 8 each: front buffer rows, to the scan driver.

## Operation
- Reset values:
  - All outputs are 0.
  - Back buffer is 0.
  - Frame counter is 0.
  - Round-robin pointer `last` = B, so A wins the first contest.
- Eligibility: requester X is eligible when `req_x`=1 and `ack_x`=0. The ack cycle is excluded so a request still held during its ack is not written twice.
- Arbitration, evaluated each cycle:
  - One eligible requester: it is granted.
  - Both eligible: the one not equal to `last` is granted.
  - A grant updates `last`.
- Grant effect at the clock edge:
  - `back[row_x] <= data_x`.
  - `ack_x` = 1 for exactly the next cycle.
  - The ungranted requester stays waiting with no ack.
- Frame counter:
  - Counts 0..FRAME_CYCLES-1 and wraps to 0.
  - The wrap edge is the cycle where the counter equals FRAME_CYCLES-1.
- Commit:
  - `commit`=1 sets `swap_pending`.
  - `commit` while already pending has no additional effect.
- Swap at a wrap edge when (`swap_pending` | `commit`):
  - Front buffer <= back buffer, all four rows in one edge.
  - `swap_pending` <= 0.
  - `swap_done` = 1 for the next cycle.
- Simultaneous events:
  - Write and swap at the same edge: the swap copies the pre-edge back contents. The new byte lands in back only and appears after the next commit.
  - Commit and wrap at the same edge: the swap occurs at that edge; `swap_pending` never rises.
- Reset mid-handshake: the write is discarded and any pending swap is cancelled. Requesters must reissue.

## Timing
- Write latency: `req` sampled at edge N with grant → `ack` high in cycle N+1. The back buffer is updated at edge N.
- Throughput:
  - Single requester: at most 1 write per 2 cycles.
  - Both requesters interleaved: 1 write per cycle total.
- Worst-case wait for a requester under contention: 1 cycle beyond its own turn.
- Commit → front visible: at most FRAME_CYCLES cycles. `swap_done` coincides with the first cycle the new front is visible.
- `leds1..4` are registered and change only at swap edges.

## Configuration
- `LED_FRAME_DOUBLE_BUFFER_EN` defined: behaviour as above.
- Undefined:
  - No back buffer; grants write the front buffer directly, visible the cycle after grant.
  - `commit` produces `swap_done` the next cycle.
  - `swap_pending` is tied to 0.
  - The frame counter is removed.

## Test plan
- Reset, A writes row 2 = 0xA5, commit: `ack_a` pulses 1 cycle after `req_a`. `leds3` stays 0 until the wrap edge, then 0xA5 with `swap_done` pulse.
- `req_a` and `req_b` held for 4 writes each, starting together: acks alternate A,B,A,B…. A is first, with one ack per cycle overall.
- `req_a` held continuously with data 0x11: acks on alternate cycles only, and each ack writes exactly once.
- Write row 0 = 0xFF at the same edge as a swap of back row 0 = 0x0F: `leds1` = 0x0F. After the next commit and wrap, `leds1` = 0xFF.
- `commit` pulsed twice within one frame: a single `swap_done`. `swap_pending` is high from the first commit until the wrap.
- `resetn` low with `swap_pending` = 1 and A mid-ack: all outputs return to 0 asynchronously and no swap occurs afterwards.
